// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, default widths
// and the header-byte to word-count mapping.
package prog_loader_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int INSTR_W_DEF = 16;
   localparam int BYTE_W_DEF  = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_HI   = 3'd2,
      ST_LO   = 3'd3,
      ST_CSUM = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } state_t;

   // A header of zero encodes a full 256-word image, hence the extra counter bit.
   function automatic logic [BYTE_W_DEF:0] hdr_count(input logic [BYTE_W_DEF-1:0] hdr);
      return (hdr == '0) ? (BYTE_W_DEF+1)'(1 << BYTE_W_DEF) : {1'b0, hdr};
   endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream loader: packs big-endian words into instruction memory, one write strobe
// 1 cycle after each low-byte accept; in_ready is a registered level, core held until checksum passes.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int BYTE_W  = BYTE_W_DEF
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               in_valid,
   input  logic [BYTE_W-1:0]  in_data,
   output logic               in_ready,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] mem_wdata,
   output logic               core_hold,
   output logic               done,
   output logic               error
);

   localparam int CNT_W = BYTE_W + 1;

   state_t              state;
   logic [CNT_W-1:0]    count;
   logic [BYTE_W-1:0]   acc;
   logic [BYTE_W-1:0]   hi_byte;
   logic                accept;

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         core_hold <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
         count     <= '0;
         acc       <= '0;
         hi_byte   <= '0;
      end else begin
         mem_we <= 1'b0;
         // Address advances on the edge that retires the pending write.
         if (mem_we)
            mem_addr <= mem_addr + 1'b1;

         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state     <= ST_HDR;
                  in_ready  <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  core_hold <= 1'b1;
                  mem_addr  <= '0;
                  acc       <= '0;
               end
            end
            ST_HDR: begin
               if (accept) begin
                  count <= hdr_count(in_data);
                  acc   <= acc ^ in_data;
                  state <= ST_HI;
               end
            end
            ST_HI: begin
               if (accept) begin
                  hi_byte <= in_data;
                  acc     <= acc ^ in_data;
                  state   <= ST_LO;
               end
            end
            ST_LO: begin
               if (accept) begin
                  acc       <= acc ^ in_data;
                  count     <= count - 1'b1;
                  mem_we    <= 1'b1;
                  mem_wdata <= {hi_byte, in_data};
                  state     <= (count != CNT_W'(1)) ? ST_HI : ST_CSUM;
               end
            end
            ST_CSUM: begin
               // Entering DONE/ERR always lands at least one edge after the last write strobe.
               if (accept) begin
                  in_ready <= 1'b0;
                  if (in_data == acc) begin
                     state     <= ST_DONE;
                     done      <= 1'b1;
                     core_hold <= 1'b0;
                  end else begin
                     state     <= ST_ERR;
                     error     <= 1'b1;
                     core_hold <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, checksum failure, 256-word wrap,
// stalls, mid-load reset and start-pulse handling.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        core_hold;
   logic        done;
   logic        error;

   int errors = 0;
   int checks = 0;

   logic [7:0]  wa_q[$];
   logic [15:0] wd_q[$];

   prog_loader #(.ADDR_W(8), .INSTR_W(16), .BYTE_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .core_hold (core_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Called and returns at posedge+1.
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      in_valid = 1'b0;
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL handshake byte %h: in_ready=%b required 1", b, in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, mem_we, done, error, core_hold} !== 5'b00001) begin
         errors++;
         $display("FAIL reset_flags: rdy/we/done/err/hold=%b required 00001",
                  {in_ready, mem_we, done, error, core_hold});
      end
      checks++;
      if ({mem_addr, mem_wdata} !== 24'h0) begin
         errors++;
         $display("FAIL reset_mem: addr/wdata=%h required 000000", {mem_addr, mem_wdata});
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({in_ready, core_hold} !== 2'b01) begin
         errors++;
         $display("FAIL idle_after_reset: rdy/hold=%b required 01", {in_ready, core_hold});
      end
   endtask

   task automatic test_load_ok();
      logic [7:0] cs;
      cs = 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD;
      wa_q.delete(); wd_q.delete();
      pulse_start();
      checks++;
      if ({in_ready, core_hold, done} !== 3'b110) begin
         errors++;
         $display("FAIL start_hdr: rdy/hold/done=%b required 110", {in_ready, core_hold, done});
      end
      send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h00, 16'h1234}) begin
         errors++;
         $display("FAIL write0: we/addr/data=%h required 1_00_1234", {mem_we, mem_addr, mem_wdata});
      end
      send_byte(8'hAB, 0); send_byte(8'hCD, 0);
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h01, 16'hABCD}) begin
         errors++;
         $display("FAIL write1: we/addr/data=%h required 1_01_ABCD", {mem_we, mem_addr, mem_wdata});
      end
      checks++;
      if ({done, core_hold} !== 2'b01) begin
         errors++;
         $display("FAIL hold_before_csum: done/hold=%b required 01", {done, core_hold});
      end
      send_byte(cs, 0);
      checks++;
      if ({done, error, core_hold, in_ready, mem_we} !== 5'b10000) begin
         errors++;
         $display("FAIL load_done: done/err/hold/rdy/we=%b required 10000",
                  {done, error, core_hold, in_ready, mem_we});
      end
      checks++;
      if (mem_addr !== 8'h02) begin
         errors++;
         $display("FAIL addr_after_load: %h required 02", mem_addr);
      end
      checks++;
      if (wa_q.size() !== 2) begin
         errors++;
         $display("FAIL write_count_ok: %0d required 2", wa_q.size());
      end
   endtask

   task automatic test_bad_csum();
      wa_q.delete(); wd_q.delete();
      pulse_start();
      checks++;
      if ({done, core_hold, mem_addr} !== {2'b01, 8'h00}) begin
         errors++;
         $display("FAIL restart: done/hold/addr=%h required 0_1_00", {done, core_hold, mem_addr});
      end
      send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
      send_byte(8'hAB, 0); send_byte(8'hCD, 0); send_byte(8'h00, 0);
      checks++;
      if ({done, error, core_hold} !== 3'b011) begin
         errors++;
         $display("FAIL bad_csum: done/err/hold=%b required 011", {done, error, core_hold});
      end
      checks++;
      if (wa_q.size() !== 2 || wd_q[0] !== 16'h1234 || wd_q[1] !== 16'hABCD) begin
         errors++;
         $display("FAIL bad_csum_writes: count=%0d required 2 with 1234,ABCD", wa_q.size());
      end
   endtask

   task automatic test_n0_wrap();
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send_byte(8'h00, 0);
      for (int i = 0; i < 256; i++) begin
         send_byte(8'(i), 0);
         send_byte(~8'(i), 0);
      end
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'hFF, 16'hFF00}) begin
         errors++;
         $display("FAIL last_write: we/addr/data=%h required 1_FF_FF00", {mem_we, mem_addr, mem_wdata});
      end
      send_byte(8'h00, 0);
      checks++;
      if ({done, error, core_hold} !== 3'b100) begin
         errors++;
         $display("FAIL n0_done: done/err/hold=%b required 100", {done, error, core_hold});
      end
      checks++;
      if (mem_addr !== 8'h00) begin
         errors++;
         $display("FAIL addr_wrap: %h required 00", mem_addr);
      end
      checks++;
      if (wa_q.size() !== 256) begin
         errors++;
         $display("FAIL n0_count: %0d required 256", wa_q.size());
      end
      for (int i = 0; i < 256 && i < wa_q.size(); i++) begin
         checks++;
         if (wa_q[i] !== 8'(i) || wd_q[i] !== {8'(i), ~8'(i)}) begin
            errors++;
            $display("FAIL n0_word%0d: addr=%h data=%h required %h %h",
                     i, wa_q[i], wd_q[i], 8'(i), {8'(i), ~8'(i)});
         end
      end
   endtask

   task automatic test_gaps();
      int         gap [6] = '{3, 0, 5, 1, 2, 4};
      logic [7:0] byt [6];
      byt = '{8'h02, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h00};
      byt[5] = 8'h02 ^ 8'h5A ^ 8'hA5 ^ 8'h3C ^ 8'hC3;
      wa_q.delete(); wd_q.delete();
      pulse_start();
      for (int k = 0; k < 6; k++) begin
         send_byte(byt[k], gap[k]);
         if (k == 2 || k == 4) begin
            checks++;
            if ({mem_we, mem_wdata} !== {1'b1, byt[k-1], byt[k]}) begin
               errors++;
               $display("FAIL gap_write%0d: we/data=%h required 1_%h%h", k, {mem_we, mem_wdata},
                        byt[k-1], byt[k]);
            end
         end
      end
      checks++;
      if ({done, error, core_hold} !== 3'b100) begin
         errors++;
         $display("FAIL gap_done: done/err/hold=%b required 100", {done, error, core_hold});
      end
      checks++;
      if (wa_q.size() !== 2 || wa_q[1] !== 8'h01 || wd_q[1] !== 16'h3CC3) begin
         errors++;
         $display("FAIL gap_writes: count=%0d required 2 ending 3CC3@01", wa_q.size());
      end
   endtask

   task automatic test_reset_midload();
      logic [7:0] cs;
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send_byte(8'h04, 0); send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({in_ready, mem_we, done, error, core_hold} !== 5'b00001) begin
         errors++;
         $display("FAIL midreset_flags: rdy/we/done/err/hold=%b required 00001",
                  {in_ready, mem_we, done, error, core_hold});
      end
      checks++;
      if ({mem_addr, mem_wdata} !== 24'h0) begin
         errors++;
         $display("FAIL midreset_mem: addr/wdata=%h required 000000", {mem_addr, mem_wdata});
      end
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      wa_q.delete(); wd_q.delete();
      pulse_start();
      cs = 8'h04;
      send_byte(8'h04, 0);
      for (int i = 0; i < 8; i++) begin
         send_byte(8'h10 + 8'(i), 0);
         cs = cs ^ (8'h10 + 8'(i));
      end
      send_byte(cs, 0);
      checks++;
      if ({done, error, core_hold} !== 3'b100) begin
         errors++;
         $display("FAIL reload_done: done/err/hold=%b required 100", {done, error, core_hold});
      end
      checks++;
      if (wa_q.size() !== 4 || wa_q[3] !== 8'h03 || wd_q[0] !== 16'h1011 || wd_q[3] !== 16'h1617) begin
         errors++;
         $display("FAIL reload_writes: count=%0d required 4 (1011@00 .. 1617@03)", wa_q.size());
      end
   endtask

   task automatic test_start_ignored();
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send_byte(8'h01, 0);
      pulse_start();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_in_hi: in_ready=%b required 1", in_ready);
      end
      send_byte(8'h77, 0); send_byte(8'h88, 0); send_byte(8'h01 ^ 8'h77 ^ 8'h88, 0);
      checks++;
      if ({done, error} !== 2'b10 || wa_q.size() !== 1 || wd_q[0] !== 16'h7788) begin
         errors++;
         $display("FAIL hi_start_load: done/err=%b writes=%0d required 10, one 7788", {done, error},
                  wa_q.size());
      end
      pulse_start();
      checks++;
      if ({done, core_hold, in_ready} !== 3'b011) begin
         errors++;
         $display("FAIL start_in_done: done/hold/rdy=%b required 011", {done, core_hold, in_ready});
      end
      wa_q.delete(); wd_q.delete();
      send_byte(8'h01, 0); send_byte(8'hAA, 0); send_byte(8'h55, 0);
      send_byte(8'h01 ^ 8'hAA ^ 8'h55, 0);
      checks++;
      if ({done, error} !== 2'b10 || wa_q.size() !== 1 || wa_q[0] !== 8'h00 || wd_q[0] !== 16'hAA55) begin
         errors++;
         $display("FAIL done_restart_load: done/err=%b writes=%0d required 10, one AA55@00",
                  {done, error}, wa_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_load_ok();
      test_bad_csum();
      test_n0_wrap();
      test_gaps();
      test_reset_midload();
      test_start_ignored();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
